// File: rtl/fifo_pkg.sv
// ============================================================================
//  fifo_pkg
//  Shared pointer type and Gray/binary helpers for the async FIFO pointer blocks
//  Rev 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int unsigned c_ADDR_WIDTH = 8;

    typedef logic [c_ADDR_WIDTH:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return (bin >> 1) ^ bin;
    endfunction

    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[c_ADDR_WIDTH] = gray[c_ADDR_WIDTH];
        for (int i = int'(c_ADDR_WIDTH) - 1; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wr_ptr_full_if.sv
// ============================================================================
//  wr_ptr_full_if
//  Producer-side bundle of the write pointer/flag block
//  Rev 1.0
// ============================================================================
`default_nettype none

interface wr_ptr_full_if
    import fifo_pkg::*;
#(
    parameter int unsigned Addr_Width = c_ADDR_WIDTH
);
    logic                  wr_en;
    logic [Addr_Width:0]   rd_ptr_sync;
    logic                  overflow_clr;
    logic                  mem_we;
    logic [Addr_Width:0]   wr_addr;
    logic [Addr_Width:0]   wr_ptr;
    logic                  full;
    logic                  almost_full;
    logic [Addr_Width:0]   wr_level;
    logic                  wr_ack;
    logic                  overflow;

    modport master (
        output wr_en, rd_ptr_sync, overflow_clr,
        input  mem_we, wr_addr, wr_ptr, full, almost_full, wr_level, wr_ack, overflow
    );

    modport slave (
        input  wr_en, rd_ptr_sync, overflow_clr,
        output mem_we, wr_addr, wr_ptr, full, almost_full, wr_level, wr_ack, overflow
    );

endinterface

`default_nettype wire

// File: rtl/gray2bin_conv.sv
// ============================================================================
//  gray2bin_conv
//  Combinational Gray-to-binary converter (XOR prefix chain from the MSB)
//  Rev 1.0
// ============================================================================
`default_nettype none

module gray2bin_conv #(
    parameter int unsigned WIDTH = 9
) (
    input  wire logic [WIDTH-1:0] gray_in,
    output logic      [WIDTH-1:0] bin_out
);

    always_comb begin
        bin_out            = '0;
        bin_out[WIDTH-1]   = gray_in[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            bin_out[i] = bin_out[i+1] ^ gray_in[i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/wr_ptr_full.sv
// ============================================================================
//  wr_ptr_full
//  Write-domain binary/Gray pointer, full, level, almost_full and overflow
//  Rev 1.0
// ============================================================================
`default_nettype none

module wr_ptr_full
    import fifo_pkg::*;
#(
    parameter int unsigned Addr_Width   = c_ADDR_WIDTH,
    parameter int unsigned AFULL_THRESH = 2**Addr_Width - 4
) (
    input  wire logic      wr_clk,
    input  wire logic      wr_rstn,
    wr_ptr_full_if.slave   bus
);

    localparam logic [Addr_Width:0] c_AFULL_THRESH = (Addr_Width+1)'(AFULL_THRESH);

    logic [Addr_Width:0] r_wr_addr;
    logic [Addr_Width:0] r_wr_ptr;
    logic [Addr_Width:0] r_wr_level;
    logic                r_full;
    logic                r_almost_full;
    logic                r_wr_ack;
    logic                r_overflow;

    logic                w_accept;
    logic                w_wr_ovf;
    logic [Addr_Width:0] w_addr_next;
    logic [Addr_Width:0] w_ptr_next;
    logic [Addr_Width:0] w_level_next;
    logic [Addr_Width:0] w_rd_bin;
    logic [Addr_Width:0] w_rd_full_cmp;
    logic                w_full_next;
    ptr_t                w_gray_ext;

    gray2bin_conv #(
        .WIDTH (Addr_Width + 1)
    ) u_rd_g2b (
        .gray_in (bus.rd_ptr_sync),
        .bin_out (w_rd_bin)
    );

    assign w_accept     = bus.wr_en & ~r_full;
    assign w_wr_ovf     = bus.wr_en & r_full;
    assign w_addr_next  = r_wr_addr + {{Addr_Width{1'b0}}, w_accept};

    // Zero-extension to the package pointer width leaves the low Gray bits unchanged
    assign w_gray_ext   = bin2gray(ptr_t'(w_addr_next));
    assign w_ptr_next   = w_gray_ext[Addr_Width:0];

    // Full when the write side is exactly one lap ahead: top two Gray bits differ
    assign w_rd_full_cmp = {~bus.rd_ptr_sync[Addr_Width:Addr_Width-1],
                            bus.rd_ptr_sync[Addr_Width-2:0]};
    assign w_full_next   = (w_ptr_next == w_rd_full_cmp);
    assign w_level_next  = w_addr_next - w_rd_bin;

    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            r_wr_addr     <= '0;
            r_wr_ptr      <= '0;
            r_wr_level    <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_wr_ack      <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_wr_addr     <= w_addr_next;
            r_wr_ptr      <= w_ptr_next;
            r_wr_level    <= w_level_next;
            r_full        <= w_full_next;
            r_almost_full <= (w_level_next >= c_AFULL_THRESH);
            r_wr_ack      <= w_accept;
            // A fresh overflow in the clear cycle is kept
            r_overflow    <= bus.overflow_clr ? w_wr_ovf : (r_overflow | w_wr_ovf);
        end
    end

    assign bus.mem_we      = w_accept;
    assign bus.wr_addr     = r_wr_addr;
    assign bus.wr_ptr      = r_wr_ptr;
    assign bus.full        = r_full;
    assign bus.almost_full = r_almost_full;
    assign bus.wr_level    = r_wr_level;
    assign bus.wr_ack      = r_wr_ack;
    assign bus.overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_wr_ptr_full.sv
// ============================================================================
//  tb_wr_ptr_full
//  Directed self-checking bench for wr_ptr_full, depth 16, almost_full at 12
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_wr_ptr_full;

    localparam int unsigned c_AW     = 4;
    localparam int unsigned c_THRESH = 12;

    logic wr_clk  = 1'b0;
    logic wr_rstn = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    wr_ptr_full_if #(.Addr_Width(c_AW)) bus ();

    wr_ptr_full #(
        .Addr_Width   (c_AW),
        .AFULL_THRESH (c_THRESH)
    ) u_dut (
        .wr_clk  (wr_clk),
        .wr_rstn (wr_rstn),
        .bus     (bus)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] g5(input logic [4:0] b);
        return b ^ {1'b0, b[4:1]};
    endfunction

    task automatic step();
        @(posedge wr_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] a_cur;
        logic [4:0] old;
        logic [4:0] rd_bin;
        logic       saw_wrap;

        bus.wr_en        = 1'b0;
        bus.rd_ptr_sync  = '0;
        bus.overflow_clr = 1'b0;

        // Reset held across edges
        step(); step();
        check_val("rst_addr",  32'(bus.wr_addr),  0);
        check_val("rst_ptr",   32'(bus.wr_ptr),   0);
        check_val("rst_full",  32'(bus.full),     0);
        check_val("rst_level", 32'(bus.wr_level), 0);
        check_val("rst_ovf",   32'(bus.overflow), 0);
        #2 wr_rstn = 1'b1;

        step();
        check_val("idle_mem_we", 32'(bus.mem_we),      0);
        check_val("idle_afull",  32'(bus.almost_full), 0);
        check_val("idle_ack",    32'(bus.wr_ack),      0);
        check_val("idle_addr",   32'(bus.wr_addr),     0);

        // Fill all 16 slots back to back
        bus.wr_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            #1 check_val("fill_mem_we", 32'(bus.mem_we), 1);
            step();
            check_val("fill_addr",  32'(bus.wr_addr),     32'(i));
            check_val("fill_ack",   32'(bus.wr_ack),      1);
            check_val("fill_level", 32'(bus.wr_level),    32'(i));
            check_val("fill_afull", 32'(bus.almost_full), (i >= 12) ? 1 : 0);
            check_val("fill_full",  32'(bus.full),        (i == 16) ? 1 : 0);
        end
        check_val("full_gray", 32'(bus.wr_ptr), 32'h18);

        // Writes while full are dropped and recorded
        for (int i = 0; i < 3; i++) begin
            #1 check_val("ovf_mem_we", 32'(bus.mem_we), 0);
            step();
            check_val("ovf_addr", 32'(bus.wr_addr),  16);
            check_val("ovf_ack",  32'(bus.wr_ack),   0);
            check_val("ovf_flag", 32'(bus.overflow), 1);
            check_val("ovf_full", 32'(bus.full),     1);
        end

        bus.overflow_clr = 1'b1;
        step();
        check_val("ovf_clr_set_wins", 32'(bus.overflow), 1);
        bus.wr_en = 1'b0;
        step();
        check_val("ovf_cleared", 32'(bus.overflow), 0);
        bus.overflow_clr = 1'b0;

        // One slot freed by the reader
        bus.rd_ptr_sync = 5'b00001;
        #1 check_val("free_full_still", 32'(bus.full), 1);
        step();
        check_val("free_full",  32'(bus.full),        0);
        check_val("free_level", 32'(bus.wr_level),    15);
        check_val("free_afull", 32'(bus.almost_full), 1);
        bus.wr_en = 1'b1;
        #1 check_val("refill_mem_we", 32'(bus.mem_we), 1);
        step();
        check_val("refill_addr",  32'(bus.wr_addr),  17);
        check_val("refill_ptr",   32'(bus.wr_ptr),   32'h19);
        check_val("refill_full",  32'(bus.full),     1);
        check_val("refill_level", 32'(bus.wr_level), 16);

        // Asynchronous reset mid-burst
        bus.rd_ptr_sync = '0;
        #2 wr_rstn = 1'b0;
        #1;
        check_val("arst_addr",  32'(bus.wr_addr),     0);
        check_val("arst_ptr",   32'(bus.wr_ptr),      0);
        check_val("arst_full",  32'(bus.full),        0);
        check_val("arst_afull", 32'(bus.almost_full), 0);
        check_val("arst_level", 32'(bus.wr_level),    0);
        check_val("arst_ack",   32'(bus.wr_ack),      0);
        step();
        check_val("arst_hold_addr", 32'(bus.wr_addr), 0);
        check_val("arst_hold_ack",  32'(bus.wr_ack),  0);
        #2 wr_rstn = 1'b1;

        // Streaming with the read pointer trailing by two cycles
        a_cur    = '0;
        rd_bin   = '0;
        saw_wrap = 1'b0;
        for (int n = 0; n < 70; n++) begin
            old = a_cur;
            step();
            a_cur = old + 5'd1;
            if (old == 5'd31 && bus.wr_addr == 5'd0) saw_wrap = 1'b1;
            check_val("strm_addr",  32'(bus.wr_addr),  32'(a_cur));
            check_val("strm_gray",  32'(bus.wr_ptr),   32'(g5(a_cur)));
            check_val("strm_1bit",  $countones(bus.wr_ptr ^ g5(old)), 1);
            check_val("strm_level", 32'(bus.wr_level), 32'(5'(a_cur - rd_bin)));
            check_val("strm_lvl_le2", 32'(bus.wr_level <= 5'd2), 1);
            check_val("strm_full",  32'(bus.full),     0);
            check_val("strm_ack",   32'(bus.wr_ack),   1);
            rd_bin          = old;
            bus.rd_ptr_sync = g5(old);
        end
        check_val("strm_wrap_seen", 32'(saw_wrap), 1);
        bus.wr_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
